// File: rtl/mod_generate_demux_pkg.sv
// Shared types and defaults for the 1-to-2 stream demultiplexer.
// The per-channel transfer counters are enabled by the macro
// MOD_GENERATE_DEMUX_CNT_EN (see mod_generate_demux.sv).
package mod_generate_demux_pkg;

    // Destination channel as carried on i_select.
    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;

    // Pick the value belonging to the addressed channel.
    function automatic logic chan_pick(input chan_e ch, input logic val_a, input logic val_b);
        return (ch == CH_B) ? val_b : val_a;
    endfunction

endpackage

// File: rtl/mod_generate_demux_slot.sv
// One-entry valid/ready holding register used for each output channel
// of the registered demux datapath.
//
// Handshake: a beat moves across an interface on every rising edge where
// valid and ready are both high; valid never depends on ready, and the
// payload is held stable while valid is high and ready is low.
module mod_generate_demux_slot
    import mod_generate_demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Next-state: a load wins over a drain so a simultaneous drain+load keeps valid high.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end
    end

    // Slot registers; reset empties the slot and clears the payload.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: rtl/mod_generate_demux.sv
// 1-to-2 stream demultiplexer: routes one valid/ready input stream to
// channel A (i_select=0) or channel B (i_select=1).
//
// REG_OUT=1 (gen_true): a one-entry holding slot per channel, one cycle of
//   latency, full throughput, and no head-of-line blocking between channels.
// REG_OUT=0 (gen_false): combinational pass-through, zero latency.
//
// Optional feature macro MOD_GENERATE_DEMUX_CNT_EN: per-channel counters of
// completed output handshakes on o_cnt_a / o_cnt_b (wrapping). When the
// macro is undefined the counters are absent and the ports read 0.
//
// Handshake: a beat transfers on every rising edge where valid and ready
// are both high. The producer keeps i_select and i_data stable while
// i_valid is high and o_ready is low.
module mod_generate_demux
    import mod_generate_demux_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_OUT = 1,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_select,
    output logic              o_ready,
    output logic              o_valid_a,
    output logic [DATA_W-1:0] o_data_a,
    input  logic              i_ready_a,
    output logic              o_valid_b,
    output logic [DATA_W-1:0] o_data_b,
    input  logic              i_ready_b,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_cnt_a,
    output logic [CNT_W-1:0]  o_cnt_b
);

    chan_e             sel_ch;
    logic              valid_a;
    logic              valid_b;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              ready_in;

    assign sel_ch = chan_e'(i_select);

    generate
        if (REG_OUT != 0) begin : gen_true
            logic load_a;
            logic load_b;

            // Accept when the addressed slot is empty or draining this cycle;
            // the other slot's state never stalls this channel.
            always_comb begin
                ready_in = chan_pick(sel_ch, !valid_a || i_ready_a, !valid_b || i_ready_b);
                load_a   = i_valid && ready_in && (sel_ch == CH_A);
                load_b   = i_valid && ready_in && (sel_ch == CH_B);
            end

            mod_generate_demux_slot #(
                .DATA_W (DATA_W)
            ) u_slot_a (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_load  (load_a),
                .i_data  (i_data),
                .i_ready (i_ready_a),
                .o_valid (valid_a),
                .o_data  (data_a)
            );

            mod_generate_demux_slot #(
                .DATA_W (DATA_W)
            ) u_slot_b (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_load  (load_b),
                .i_data  (i_data),
                .i_ready (i_ready_b),
                .o_valid (valid_b),
                .o_data  (data_b)
            );
        end else begin : gen_false
            // Pure steering; outputs are forced quiet while reset is held so
            // reset looks the same from the consumers' side in both builds.
            always_comb begin
                valid_a  = i_valid && (sel_ch == CH_A) && i_rst_n;
                valid_b  = i_valid && (sel_ch == CH_B) && i_rst_n;
                data_a   = i_rst_n ? i_data : '0;
                data_b   = i_rst_n ? i_data : '0;
                ready_in = chan_pick(sel_ch, i_ready_a, i_ready_b);
            end
        end
    endgenerate

    assign o_ready   = ready_in;
    assign o_valid_a = valid_a;
    assign o_valid_b = valid_b;
    assign o_data_a  = data_a;
    assign o_data_b  = data_b;
    assign o_busy    = valid_a | valid_b;

`ifdef MOD_GENERATE_DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_a_q;
    logic [CNT_W-1:0] cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q;
    logic [CNT_W-1:0] cnt_b_d;

    // Count output handshakes per channel; natural wrap at 2^CNT_W.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (valid_a && i_ready_a) begin
            cnt_a_d = cnt_a_q + CNT_W'(1);
        end
        if (valid_b && i_ready_b) begin
            cnt_b_d = cnt_b_q + CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign o_cnt_a = cnt_a_q;
    assign o_cnt_b = cnt_b_q;
`else
    assign o_cnt_a = '0;
    assign o_cnt_b = '0;
`endif

endmodule

// File: tb/tb_mod_generate_demux.sv
// Bench for mod_generate_demux: a registered (REG_OUT=1) and a
// combinational (REG_OUT=0) instance share one producer and one pair of
// consumers; a queue-based channel model predicts both.
module tb_mod_generate_demux;

    localparam int DW = 8;
    localparam int CW = 4;
`ifdef MOD_GENERATE_DEMUX_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          i_select;
    logic          ra;
    logic          rb;

    logic          m_ready, m_valid_a, m_valid_b, m_busy;
    logic [DW-1:0] m_data_a, m_data_b;
    logic [CW-1:0] m_cnt_a, m_cnt_b;
    logic          c_ready, c_valid_a, c_valid_b, c_busy;
    logic [DW-1:0] c_data_a, c_data_b;
    logic [CW-1:0] c_cnt_a, c_cnt_b;

    mod_generate_demux #(.DATA_W(DW), .REG_OUT(1), .CNT_W(CW)) u_reg (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
        .i_select(i_select), .o_ready(m_ready),
        .o_valid_a(m_valid_a), .o_data_a(m_data_a), .i_ready_a(ra),
        .o_valid_b(m_valid_b), .o_data_b(m_data_b), .i_ready_b(rb),
        .o_busy(m_busy), .o_cnt_a(m_cnt_a), .o_cnt_b(m_cnt_b)
    );

    mod_generate_demux #(.DATA_W(DW), .REG_OUT(0), .CNT_W(CW)) u_comb (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
        .i_select(i_select), .o_ready(c_ready),
        .o_valid_a(c_valid_a), .o_data_a(c_data_a), .i_ready_a(ra),
        .o_valid_b(c_valid_b), .o_data_b(c_data_b), .i_ready_b(rb),
        .o_busy(c_busy), .o_cnt_a(c_cnt_a), .o_cnt_b(c_cnt_b)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered instance: each channel is a FIFO of capacity one.
    logic [DW-1:0] exp_qa[$];
    logic [DW-1:0] exp_qb[$];
    int  cnt_ma, cnt_mb, cnt_ca, cnt_cb;
    bit  acc_m, acc_c;

    function automatic int cnt_exp(input int n);
        return CNT_ON ? (n % (1 << CW)) : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit out_a, out_b, rdy_m;
        if (!rst_n) begin
            exp_qa.delete();
            exp_qb.delete();
            cnt_ma = 0; cnt_mb = 0; cnt_ca = 0; cnt_cb = 0;
            acc_m = 1'b0; acc_c = 1'b0;
        end else begin
            out_a = (exp_qa.size() != 0) && ra;
            out_b = (exp_qb.size() != 0) && rb;
            rdy_m = i_select ? (exp_qb.size() == 0 || rb) : (exp_qa.size() == 0 || ra);
            acc_m = i_valid && rdy_m;
            acc_c = i_valid && (i_select ? rb : ra);
            if (out_a) begin void'(exp_qa.pop_front()); cnt_ma++; end
            if (out_b) begin void'(exp_qb.pop_front()); cnt_mb++; end
            if (acc_m) begin
                if (i_select) exp_qb.push_back(i_data);
                else          exp_qa.push_back(i_data);
            end
            if (i_valid && !i_select && ra) cnt_ca++;
            if (i_valid &&  i_select && rb) cnt_cb++;
        end
    end

    // Per-cycle comparison, done on the falling edge before new stimulus.
    always @(negedge clk) begin
        if (rst_n) begin
            check("m_valid_a", m_valid_a, exp_qa.size() != 0);
            check("m_valid_b", m_valid_b, exp_qb.size() != 0);
            if (exp_qa.size() != 0) check("m_data_a", m_data_a, exp_qa[0]);
            if (exp_qb.size() != 0) check("m_data_b", m_data_b, exp_qb[0]);
            check("m_ready", m_ready,
                  i_select ? (exp_qb.size() == 0 || rb) : (exp_qa.size() == 0 || ra));
            check("m_busy", m_busy, exp_qa.size() != 0 || exp_qb.size() != 0);
            check("m_cnt_a", m_cnt_a, cnt_exp(cnt_ma));
            check("m_cnt_b", m_cnt_b, cnt_exp(cnt_mb));
            check("c_valid_a", c_valid_a, i_valid && !i_select);
            check("c_valid_b", c_valid_b, i_valid && i_select);
            check("c_data_a", c_data_a, i_data);
            check("c_data_b", c_data_b, i_data);
            check("c_ready", c_ready, i_select ? rb : ra);
            check("c_busy", c_busy, i_valid);
            check("c_cnt_a", c_cnt_a, cnt_exp(cnt_ca));
            check("c_cnt_b", c_cnt_b, cnt_exp(cnt_cb));
        end
    end

    // ---------------- driver ----------------
    // Stimulus changes 2 time units after the falling edge.
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_select = 1'b0; ra = 1'b0; rb = 1'b0;
        repeat (3) step();
        check("rst_valid_a", m_valid_a, 1'b0);
        check("rst_data_a", m_data_a, 8'h00);
        check("rst_cnt_a", m_cnt_a, 4'h0);
        check("rst_busy", m_busy, 1'b0);
        rst_n = 1'b1;

        // Streaming to A, one cycle of latency, full rate.
        step();
        ra = 1'b1; rb = 1'b1; i_valid = 1'b1; i_select = 1'b0; i_data = 8'h11;
        #1 check("t2_ready0", m_ready, 1'b1);
        step();
        check("t2_valid0", m_valid_a, 1'b1);
        check("t2_data0", m_data_a, 8'h11);
        i_data = 8'h22;
        #1 check("t2_ready1", m_ready, 1'b1);
        step();
        check("t2_data1", m_data_a, 8'h22);
        i_data = 8'h33;
        #1 check("t2_ready2", m_ready, 1'b1);
        step();
        check("t2_data2", m_data_a, 8'h33);
        i_valid = 1'b0;
        step();

        // A stalls holding 0xAA; B still accepts 0x55.
        ra = 1'b0; i_valid = 1'b1; i_select = 1'b0; i_data = 8'hAA;
        step();
        check("t3_valid_a", m_valid_a, 1'b1);
        check("t3_data_a", m_data_a, 8'hAA);
        i_valid = 1'b0;
        #1 check("t3_ready_sel_a", m_ready, 1'b0);
        i_select = 1'b1; i_data = 8'h55; i_valid = 1'b1; rb = 1'b1;
        #1 check("t3_ready_sel_b", m_ready, 1'b1);
        step();
        check("t3_valid_b", m_valid_b, 1'b1);
        check("t3_data_b", m_data_b, 8'h55);
        check("t3_hold_a", m_data_a, 8'hAA);
        i_valid = 1'b0; i_select = 1'b0;

        // Drain and load A in the same cycle: no bubble.
        i_valid = 1'b1; i_data = 8'h7E; ra = 1'b1;
        #1 check("t4_ready", m_ready, 1'b1);
        step();
        check("t4_valid_a", m_valid_a, 1'b1);
        check("t4_data_a", m_data_a, 8'h7E);
        i_valid = 1'b0; ra = 1'b0;

        // Asynchronous reset with A full.
        step();
        check("t1_full_a", m_valid_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t1_valid_a", m_valid_a, 1'b0);
        check("t1_data_a", m_data_a, 8'h00);
        check("t1_cnt_a", m_cnt_a, 4'h0);
        step();
        rst_n = 1'b1;
        #1 check("t1_ready", m_ready, 1'b1);

        // 17 handshakes on B: counter wraps to 1 when enabled.
        rb = 1'b1; i_valid = 1'b1; i_select = 1'b1;
        for (int k = 0; k < 17; k++) begin
            i_data = DW'($urandom_range(0, 255));
            step();
        end
        i_valid = 1'b0;
        step();
        check("t6_cnt_b", m_cnt_b, CNT_ON ? 4'h1 : 4'h0);
        check("t6_cnt_a", m_cnt_a, 4'h0);
        check("t6_comb_cnt_b", c_cnt_b, CNT_ON ? 4'h1 : 4'h0);

        // Combinational build: same-cycle routing and backpressure.
        i_valid = 1'b1; i_select = 1'b1; i_data = 8'hC3; rb = 1'b0;
        #1;
        check("t5_valid_b", c_valid_b, 1'b1);
        check("t5_valid_a", c_valid_a, 1'b0);
        check("t5_ready", c_ready, 1'b0);
        check("t5_data_b", c_data_b, 8'hC3);

        // Random traffic; a beat not taken by both instances is held.
        for (int k = 0; k < 3000; k++) begin
            step();
            if (!(i_valid && !(acc_m && acc_c))) begin
                i_valid  = ($urandom_range(0, 3) != 0);
                i_select = 1'($urandom_range(0, 1));
                i_data   = DW'($urandom_range(0, 255));
            end
            ra = ($urandom_range(0, 3) != 0);
            rb = ($urandom_range(0, 3) != 0);
        end
        i_valid = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
